// File: rtl/huffman_code_length_update.sv
// Huffman code-length accumulator. Each leaf emitted by the downward traversal
// adds one to that symbol's code length. When the tree is complete, the block
// streams all DEPTH lengths in symbol order over a valid/ready interface.
module huffman_code_length_update #(
  parameter int unsigned SYM_W = 8,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned DEPTH = 256
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             clr_start,
  output logic             busy,
  input  logic [SYM_W-1:0] leaf_number,
  input  logic             leaf_number_valid,
  input  logic             trav_done,
  input  logic             build_done,
  output logic [SYM_W-1:0] merge_cnt,
  output logic [SYM_W-1:0] len_symbol,
  output logic [LEN_W-1:0] len_value,
  output logic             len_valid,
  input  logic             len_ready,
  output logic             dump_done,
  output logic [LEN_W-1:0] max_len,
  output logic             len_overflow
);

  localparam logic [SYM_W-1:0] LastSym = SYM_W'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StDump} state_e;

  state_e           state_q, state_d;
  logic [SYM_W-1:0] cnt_q, cnt_d;
  logic [SYM_W:0]   dump_addr_q, dump_addr_d;  // MSB marks all symbols fetched
  logic             s1_valid_q, s1_valid_d;
  logic [SYM_W-1:0] s1_addr_q;
  logic [LEN_W-1:0] rd_a_q;
  logic             s2_valid_q;
  logic [SYM_W-1:0] s2_addr_q;
  logic [LEN_W-1:0] s2_data_q;
  logic [SYM_W-1:0] merge_cnt_q, merge_cnt_d;
  logic [LEN_W-1:0] max_len_q, max_len_d;
  logic             ovf_q, ovf_d;
  logic             len_valid_q, len_valid_d;
  logic [SYM_W-1:0] len_symbol_q, len_symbol_d;
  logic [LEN_W-1:0] rd_b_q;
  logic             dump_done_q, dump_done_d;

  logic [LEN_W-1:0] mem_q [DEPTH];

  logic             kill;
  logic [LEN_W-1:0] old_len;
  logic             sat;
  logic [LEN_W-1:0] new_len;
  logic             a_we;
  logic             b_we;
  logic             b_re;
  logic             last_accept;

  // Read-modify-write datapath with forwarding of the previous write
  always_comb begin
    kill        = (state_q == StAccum) && clr_start;
    old_len     = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q : rd_a_q;
    sat         = (old_len == '1);
    new_len     = sat ? old_len : old_len + 1'b1;
    a_we        = s1_valid_q && !kill;
    b_we        = (state_q == StClear);
    b_re        = (state_q == StDump) && !dump_addr_q[SYM_W] && (!len_valid_q || len_ready);
    last_accept = len_valid_q && len_ready && (len_symbol_q == LastSym);
  end

  // Next-state logic for the FSM, counters and sticky status
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dump_addr_d  = dump_addr_q;
    s1_valid_d   = 1'b0;
    merge_cnt_d  = merge_cnt_q;
    max_len_d    = max_len_q;
    ovf_d        = ovf_q;
    len_valid_d  = len_valid_q;
    len_symbol_d = len_symbol_q;
    dump_done_d  = 1'b0;

    if (a_we) begin
      if (new_len > max_len_q) max_len_d = new_len;
      if (sat) ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d       = cnt_q + 1'b1;
        merge_cnt_d = '0;
        max_len_d   = '0;
        ovf_d       = 1'b0;
        if (cnt_q == LastSym) state_d = StAccum;
      end
      StAccum: begin
        if (clr_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end else begin
          s1_valid_d = leaf_number_valid;
          if (trav_done) merge_cnt_d = merge_cnt_q + 1'b1;
          if (build_done) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SYM_W'(1)) begin
          state_d     = StDump;
          dump_addr_d = '0;
          len_valid_d = 1'b0;
        end
      end
      StDump: begin
        if (b_re) begin
          dump_addr_d  = dump_addr_q + 1'b1;
          len_symbol_d = dump_addr_q[SYM_W-1:0];
          len_valid_d  = 1'b1;
        end
        if (last_accept) begin
          len_valid_d = 1'b0;
          dump_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pipeline and output registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      dump_addr_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      rd_a_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      merge_cnt_q  <= '0;
      max_len_q    <= '0;
      ovf_q        <= 1'b0;
      len_valid_q  <= 1'b0;
      len_symbol_q <= '0;
      rd_b_q       <= '0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dump_addr_q  <= dump_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= leaf_number;
      rd_a_q       <= mem_q[leaf_number];
      s2_valid_q   <= a_we;
      if (a_we) begin
        s2_addr_q <= s1_addr_q;
        s2_data_q <= new_len;
      end
      merge_cnt_q  <= merge_cnt_d;
      max_len_q    <= max_len_d;
      ovf_q        <= ovf_d;
      len_valid_q  <= len_valid_d;
      len_symbol_q <= len_symbol_d;
      if (b_re) rd_b_q <= mem_q[dump_addr_q[SYM_W-1:0]];
      dump_done_q  <= dump_done_d;
    end
  end

  // Length storage: port A takes RMW writes, port B takes clear writes
  always_ff @(posedge clk) begin
    if (a_we) mem_q[s1_addr_q] <= new_len;
    if (b_we) mem_q[cnt_q] <= '0;
  end

  assign busy         = (state_q == StClear) || (state_q == StDump);
  assign merge_cnt    = merge_cnt_q;
  assign len_symbol   = len_symbol_q;
  assign len_value    = rd_b_q;
  assign len_valid    = len_valid_q;
  assign dump_done    = dump_done_q;
  assign max_len      = max_len_q;
  assign len_overflow = ovf_q;

endmodule
